// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared opcode, ALU select and state encodings for the TD4 sequencer
package td4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [3:0] OP_ADD_A   = 4'h0;
    localparam logic [3:0] OP_MOV_A_B = 4'h1;
    localparam logic [3:0] OP_IN_A    = 4'h2;
    localparam logic [3:0] OP_MOV_A   = 4'h3;
    localparam logic [3:0] OP_MOV_B_A = 4'h4;
    localparam logic [3:0] OP_ADD_B   = 4'h5;
    localparam logic [3:0] OP_IN_B    = 4'h6;
    localparam logic [3:0] OP_MOV_B   = 4'h7;
    localparam logic [3:0] OP_OUT_B   = 4'h9;
    localparam logic [3:0] OP_OUT_IMM = 4'hB;
    localparam logic [3:0] OP_JNC     = 4'hE;
    localparam logic [3:0] OP_JMP     = 4'hF;

endpackage

// File: rtl/insn_decoder.sv
// rtl/insn_decoder.sv - combinational opcode decode to load enables, ALU select and jump-taken
module insn_decoder
    import td4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] opcode_i,
    input  logic         carry_i,
    output logic         ld_a_n_o,
    output logic         ld_b_n_o,
    output logic         ld_out_n_o,
    output logic [1:0]   sel_o,
    output logic         jump_taken_o,
    output logic         carry_we_o
);

    always_comb begin
        ld_a_n_o     = 1'b1;
        ld_b_n_o     = 1'b1;
        ld_out_n_o   = 1'b1;
        sel_o        = SEL_ZERO;
        jump_taken_o = 1'b0;
        carry_we_o   = 1'b1;
        case (opcode_i)
            W'(OP_ADD_A):   begin ld_a_n_o   = 1'b0; sel_o = SEL_A;    end
            W'(OP_MOV_A_B): begin ld_a_n_o   = 1'b0; sel_o = SEL_B;    end
            W'(OP_IN_A):    begin ld_a_n_o   = 1'b0; sel_o = SEL_IN;   end
            W'(OP_MOV_A):   begin ld_a_n_o   = 1'b0; sel_o = SEL_ZERO; end
            W'(OP_MOV_B_A): begin ld_b_n_o   = 1'b0; sel_o = SEL_A;    end
            W'(OP_ADD_B):   begin ld_b_n_o   = 1'b0; sel_o = SEL_B;    end
            W'(OP_IN_B):    begin ld_b_n_o   = 1'b0; sel_o = SEL_IN;   end
            W'(OP_MOV_B):   begin ld_b_n_o   = 1'b0; sel_o = SEL_ZERO; end
            W'(OP_OUT_B):   begin ld_out_n_o = 1'b0; sel_o = SEL_B;    end
            W'(OP_OUT_IMM): begin ld_out_n_o = 1'b0; sel_o = SEL_ZERO; end
            W'(OP_JNC):     begin jump_taken_o = ~carry_i; carry_we_o = 1'b0; end
            W'(OP_JMP):     begin jump_taken_o = 1'b1;     carry_we_o = 1'b0; end
            // Undefined opcodes fall through as NOP and leave the carry alone
            default:        carry_we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer driving an external program counter
module instruction_sequencer
    import td4_pkg::*;
#(
    parameter int bitWidth = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  RUN,
    input  logic [2*bitWidth-1:0] INSN,
    input  logic [bitWidth-1:0]   PC_Q,
    input  logic                  CY_IN,
    output logic                  PC_CS,
    output logic [bitWidth-1:0]   PC_D,
    output logic                  LD_A_N,
    output logic                  LD_B_N,
    output logic                  LD_OUT_N,
    output logic [1:0]            SEL,
    output logic [bitWidth-1:0]   IMM,
    output logic                  CARRY,
    output logic                  HALTED
);

    state_e                state_q, state_d;
    logic [2*bitWidth-1:0] ir_q, ir_d;
    logic                  carry_q, carry_d;

    logic                  dec_ld_a_n, dec_ld_b_n, dec_ld_out_n;
    logic                  dec_jump, dec_carry_we;

    assign IMM   = ir_q[bitWidth-1:0];
    assign CARRY = carry_q;

    insn_decoder #(
        .W (bitWidth)
    ) u_insn_decoder (
        .opcode_i     (ir_q[2*bitWidth-1:bitWidth]),
        .carry_i      (carry_q),
        .ld_a_n_o     (dec_ld_a_n),
        .ld_b_n_o     (dec_ld_b_n),
        .ld_out_n_o   (dec_ld_out_n),
        .sel_o        (SEL),
        .jump_taken_o (dec_jump),
        .carry_we_o   (dec_carry_we)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (RUN) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = INSN;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_carry_we) carry_d = CY_IN;
                // A taken jump onto its own address can never make progress
                if (dec_jump && (IMM == PC_Q)) state_d = ST_HALT;
                else if (RUN)                  state_d = ST_FETCH;
                else                           state_d = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outside EXEC the PC reloads its own value so it holds still
    always_comb begin
        PC_CS    = 1'b0;
        PC_D     = PC_Q;
        LD_A_N   = 1'b1;
        LD_B_N   = 1'b1;
        LD_OUT_N = 1'b1;
        HALTED   = 1'b0;
        case (state_q)
            ST_EXEC: begin
                LD_A_N   = dec_ld_a_n;
                LD_B_N   = dec_ld_b_n;
                LD_OUT_N = dec_ld_out_n;
                if (dec_jump) PC_D  = IMM;
                else          PC_CS = 1'b1;
            end
            ST_HALT: HALTED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter SHALL be: bitWidth, 4, width of PC, immediate field and opcode field.
REQ-002 CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 CLR  input  1  asynchronous active-low reset.
REQ-004 RUN  input  1  high = execute program; low = pause at instruction boundary.
REQ-005 INSN  input  2*bitWidth  ROM word at address PC_Q; upper half opcode, lower half immediate.
REQ-006 PC_Q  input  bitWidth  current program counter value.
REQ-007 CY_IN  input  1  ALU carry-out of the current EXEC cycle.
REQ-008 PC_CS  output  1  active-low load strobe to program counter; high = PC counts up.
REQ-009 PC_D  output  bitWidth  value loaded into PC when PC_CS low.
REQ-010 LD_A_N, LD_B_N, LD_OUT_N  output  1 each  active-low register load enables.
REQ-011 SEL  output  2  ALU source: 00 A, 01 B, 10 IN port, 11 zero.
REQ-012 IMM  output  bitWidth  immediate field of latched instruction.
REQ-013 CARRY  output  1  carry flag; HALTED  output  1  self-jump halt indicator.

Function
REQ-014 FSM SHALL have states IDLE, FETCH, EXEC, HALT.
REQ-015 IDLE: RUN low stays; RUN high -> FETCH next edge.
REQ-016 FETCH: IR <= INSN; -> EXEC unconditionally.
REQ-017 EXEC: perform decoded action; -> HALT on self-jump, else -> FETCH if RUN high, else IDLE.
REQ-018 HALT SHALL be left only by reset.
REQ-019 In IDLE, FETCH, HALT: PC_CS=0 and PC_D=PC_Q (PC held by self-reload); all LD_*_N=1.
REQ-020 In EXEC non-jump: PC_CS=1 (PC increments, wrapping F->0).
REQ-021 Decode (opcode -> action, SEL): 0000 A<=A+IMM,00; 0001 A<=B,01; 0010 A<=IN,10; 0011 A<=IMM,11; 0100 B<=A,00; 0101 B<=B+IMM,01; 0110 B<=IN,10; 0111 B<=IMM,11; 1001 OUT<=B,01; 1011 OUT<=IMM,11; 1110 JNC; 1111 JMP.
REQ-022 Load enables SHALL be low for exactly the one EXEC cycle of the targeted register.
REQ-023 JMP: PC_CS=0, PC_D=IMM; JNC: same if CARRY=0, else PC_CS=1 (fall through).
REQ-024 Undefined opcodes SHALL execute as NOP: no loads, PC increments, CARRY unchanged.
REQ-025 CARRY SHALL load CY_IN at end of every EXEC of opcodes 0000-1011 defined above; unchanged on JMP/JNC/NOP.
REQ-026 Self-jump: taken JMP/JNC with IMM == PC_Q SHALL enter HALT; HALTED=1 in HALT only.
REQ-027 Every instruction SHALL take exactly 2 cycles (FETCH+EXEC).
REQ-028 RUN falling mid-instruction SHALL complete the current EXEC before IDLE.
REQ-029 SEL and IMM SHALL be driven from IR in all states.

Reset
REQ-030 CLR low SHALL immediately force state IDLE, IR=0, CARRY=0, HALTED=0, LD_*_N=1, PC_CS=0, PC_D=PC_Q.
REQ-031 CLR asserted during EXEC SHALL suppress that cycle's loads and carry update.
REQ-032 Program counter SHALL share CLR; after release first FETCH reads address 0.

Structure
REQ-033 Opcode constants, SEL encodings and state encoding SHALL reside in a shared td4 package/header.
REQ-034 Combinational opcode decoder SHALL be sub-module insn_decoder (IR opcode, CARRY -> loads, SEL, jump-taken).
REQ-035 Block SHALL instantiate no program counter; it drives an external ProgramCounter via PC_CS/PC_D.

Verification
REQ-036 Reset, RUN=1, ROM 0:3 1 (MOV A,1), 1:0 2 (ADD A,2) -> LD_A_N low at cycles 2,4; SEL 11 then 00; PC 0->1->2.
REQ-037 A+IMM with CY_IN=1 then JNC 8 -> CARRY=1, PC falls through to next address, not 8.
REQ-038 CY_IN=0 ADD then JNC 8 -> PC_Q=8 after EXEC.
REQ-039 JMP 5 at address 5 -> HALTED=1 two cycles later, PC_Q stays 5 for 20 cycles, RUN ignored.
REQ-040 RUN dropped in FETCH -> EXEC completes, then IDLE, PC frozen; RUN high resumes at next address.
REQ-041 CLR low during EXEC of MOV B,7 -> LD_B_N never low, state IDLE, CARRY=0.
